// File: rtl/lru_alloc_pkg.sv
// Shared types and limits for the replacement-way allocator and its helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: allocator FSM state enum and the largest supported associativity.
package lru_alloc_pkg;

  // Largest supported log2(associativity); the allocator is legal for 1..this.
  localparam int max_ways_log2_c = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    FILL  = 2'd2
  } lru_alloc_state_e;

endpackage

// File: rtl/lru_victim_pick.sv
// Victim chooser: lowest-index invalid way, else highest-priority way (ties to lowest index).
// Latency: purely combinational.
// Backpressure: none; no handshake, output follows inputs.
//
// Ports:
//   valid  per-way valid bits
//   prio   per-way replacement priority, higher evicts first
//   victim chosen way
module lru_victim_pick
  import lru_alloc_pkg::*;
#(
  parameter  int ways_log2_p = 2,
  localparam int ways_lp     = 1 << ways_log2_p
) (
  input  logic [ways_lp-1:0]                  valid,
  input  logic [ways_lp-1:0][ways_log2_p-1:0] prio,
  output logic [ways_log2_p-1:0]              victim
);

  logic                   found_invalid;
  logic [ways_log2_p-1:0] best_prio;

  always_comb begin
    found_invalid = 1'b0;
    best_prio     = prio[0];
    victim        = '0;

    // An empty way always beats evicting live data.
    for (int i = 0; i < ways_lp; i++) begin
      if (!found_invalid && !valid[i]) begin
        victim        = ways_log2_p'(i);
        found_invalid = 1'b1;
      end
    end

    // Strict '>' keeps the earliest (lowest-index) way on ties.
    if (!found_invalid) begin
      for (int i = 1; i < ways_lp; i++) begin
        if (prio[i] > best_prio) begin
          best_prio = prio[i];
          victim    = ways_log2_p'(i);
        end
      end
    end
  end

endmodule

// File: rtl/lru_way_allocator.sv
// Fill-victim allocator for one cache set; owns the PLRU tracker's single touch port.
// Latency: request->grant 1 cycle; touch path combinational; deferred touch +1 cycle.
// Backpressure: alloc_ready_o low outside IDLE; grant held until alloc_yumi_i.
//
// Ports:
//   clk_i, reset_i                 clock, synchronous active-high reset
//   priority_i                     per-way PLRU priority (higher = evict first)
//   hit_v_i/hit_way_i              hit touch request
//   inval_v_i/inval_way_i          invalidate request (ignored for the locked way)
//   alloc_v_i/alloc_ready_o        allocation request handshake
//   alloc_v_o/alloc_way_o/alloc_yumi_i  victim grant handshake
//   fill_done_v_i/fill_way_i       fill completion for the locked way
//   lru_v_o/lru_index_o            touch strobe/index to the tracker
//   way_valid_o                    per-way valid bits
module lru_way_allocator
  import lru_alloc_pkg::*;
#(
  parameter  int ways_log2_p = 2,
  localparam int ways_lp     = 1 << ways_log2_p
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic [ways_lp-1:0][ways_log2_p-1:0] priority_i,
  input  logic                                hit_v_i,
  input  logic [ways_log2_p-1:0]              hit_way_i,
  input  logic                                inval_v_i,
  input  logic [ways_log2_p-1:0]              inval_way_i,
  input  logic                                alloc_v_i,
  output logic                                alloc_ready_o,
  output logic                                alloc_v_o,
  output logic [ways_log2_p-1:0]              alloc_way_o,
  input  logic                                alloc_yumi_i,
  input  logic                                fill_done_v_i,
  input  logic [ways_log2_p-1:0]              fill_way_i,
  output logic                                lru_v_o,
  output logic [ways_log2_p-1:0]              lru_index_o,
  output logic [ways_lp-1:0]                  way_valid_o
);

  lru_alloc_state_e       state_r, state_n;
  logic [ways_lp-1:0]     valid_r, valid_n;
  logic                   lock_v_r, lock_v_n;
  logic [ways_log2_p-1:0] lock_way_r, lock_way_n;
  logic [ways_log2_p-1:0] way_r, way_n;
  logic                   defer_v_r, defer_v_n;
  logic [ways_log2_p-1:0] defer_way_r, defer_way_n;

  logic [ways_log2_p-1:0] victim_way;
  logic                   fill_touch;

  // Selection sees pre-invalidate valid bits, so a same-cycle invalidate
  // does not steer the victim.
  lru_victim_pick #(
    .ways_log2_p(ways_log2_p)
  ) u_victim_pick (
    .valid (valid_r),
    .prio  (priority_i),
    .victim(victim_way)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r     <= IDLE;
      valid_r     <= '0;
      lock_v_r    <= 1'b0;
      lock_way_r  <= '0;
      way_r       <= '0;
      defer_v_r   <= 1'b0;
      defer_way_r <= '0;
    end else begin
      state_r     <= state_n;
      valid_r     <= valid_n;
      lock_v_r    <= lock_v_n;
      lock_way_r  <= lock_way_n;
      way_r       <= way_n;
      defer_v_r   <= defer_v_n;
      defer_way_r <= defer_way_n;
    end
  end

  always_comb begin
    state_n       = state_r;
    valid_n       = valid_r;
    lock_v_n      = lock_v_r;
    lock_way_n    = lock_way_r;
    way_n         = way_r;
    defer_v_n     = 1'b0;
    defer_way_n   = defer_way_r;
    fill_touch    = 1'b0;
    alloc_ready_o = 1'b0;
    alloc_v_o     = 1'b0;
    alloc_way_o   = '0;
    lru_v_o       = 1'b0;
    lru_index_o   = '0;

    // Invalidate first so a fill completing this cycle can still set its bit;
    // the way being filled is protected by the lock anyway.
    if (inval_v_i && !(lock_v_r && (lock_way_r == inval_way_i))) begin
      valid_n[inval_way_i] = 1'b0;
    end

    case (state_r)
      IDLE: begin
        alloc_ready_o = 1'b1;
        if (alloc_v_i) begin
          way_n   = victim_way;
          state_n = GRANT;
        end
      end
      GRANT: begin
        alloc_v_o   = 1'b1;
        alloc_way_o = way_r;
        if (alloc_yumi_i) begin
          lock_v_n   = 1'b1;
          lock_way_n = way_r;
          state_n    = FILL;
        end
      end
      FILL: begin
        if (fill_done_v_i && (fill_way_i == way_r)) begin
          valid_n[way_r] = 1'b1;
          lock_v_n       = 1'b0;
          fill_touch     = 1'b1;
          state_n        = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    // Tracker port: deferred touch, then hit, then fill completion. The slot
    // drains whenever it wins, so it is free to take the next loser.
    if (defer_v_r) begin
      lru_v_o     = 1'b1;
      lru_index_o = defer_way_r;
      // Should a hit and a fill both lose here, the hit keeps the slot.
      if (hit_v_i) begin
        defer_v_n   = 1'b1;
        defer_way_n = hit_way_i;
      end else if (fill_touch) begin
        defer_v_n   = 1'b1;
        defer_way_n = way_r;
      end
    end else if (hit_v_i) begin
      lru_v_o     = 1'b1;
      lru_index_o = hit_way_i;
      if (fill_touch) begin
        defer_v_n   = 1'b1;
        defer_way_n = way_r;
      end
    end else if (fill_touch) begin
      lru_v_o     = 1'b1;
      lru_index_o = way_r;
    end

    // Registered state may still be stale during the reset cycle; keep every
    // output quiet until it has been cleared.
    if (reset_i) begin
      alloc_ready_o = 1'b0;
      alloc_v_o     = 1'b0;
      alloc_way_o   = '0;
      lru_v_o       = 1'b0;
      lru_index_o   = '0;
    end
  end

  assign way_valid_o = reset_i ? '0 : valid_r;

endmodule
